// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage:
//   - XLEN              : address / instruction width
//   - NOP_INST_DEFAULT  : word placed in the output slot for an address-error fetch
//   - if_state_e        : fetch FSM state encoding
package inst_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = '0;

  // S_IDLE : no request outstanding
  // S_WAIT : one request outstanding, its data fills the slot
  // S_DROP : one request outstanding, its data is discarded
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction-fetch stage between the PC register and decode. Issues the
//   current PC to the instruction SRAM (req/addr_ok/data_ok), keeps one
//   request in flight, holds the returned word in a one-entry slot until
//   decode takes it, and discards responses made stale by a redirect.
//
//   Ports:
//     clk, resetn                 clock, async active-low reset
//     pc, illegal_pc_if           current fetch address and its misalignment flag
//     flush                       redirect this cycle
//     pc_en                       PC register update enable
//     inst_sram_req/addr          fetch request and address (addr == pc)
//     inst_sram_addr_ok           address accepted
//     inst_sram_data_ok/rdata     read data return, in order
//     id_allowin                  decode accepts the slot this cycle
//     if_valid/if_pc/if_inst/if_adel  output slot
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] pc,
  input  logic            illegal_pc_if,
  input  logic            flush,
  output logic            pc_en,
  output logic            inst_sram_req,
  output logic [XLEN-1:0] inst_sram_addr,
  input  logic            inst_sram_addr_ok,
  input  logic            inst_sram_data_ok,
  input  logic [XLEN-1:0] inst_sram_rdata,
  input  logic            id_allowin,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_adel
);

  if_state_e       state_q;
  if_state_e       state_d;
  logic [XLEN-1:0] req_pc;

  logic slot_free;
  logic in_idle;
  logic accept;
  logic ill_load;
  logic fill;

  // A request only issues when the slot is free, so the slot never overflows.
  assign slot_free      = !if_valid || id_allowin;
  assign in_idle        = (state_q == S_IDLE);
  assign inst_sram_req  = in_idle && slot_free && !flush && !illegal_pc_if && resetn;
  assign inst_sram_addr = pc;
  assign accept         = inst_sram_req && inst_sram_addr_ok;
  // Misaligned PC: bypass the SRAM and load an error entry straight into the slot.
  assign ill_load       = in_idle && slot_free && !flush && illegal_pc_if;
  assign pc_en          = (accept || ill_load || flush) && resetn;
  assign fill           = (state_q == S_WAIT) && inst_sram_data_ok && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        // A response coinciding with the redirect settles the outstanding
        // request, so there is nothing left to drop.
        if (flush)                  state_d = inst_sram_data_ok ? S_IDLE : S_DROP;
        else if (inst_sram_data_ok) state_d = S_IDLE;
      end
      S_DROP: if (inst_sram_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      req_pc  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_pc <= pc;
    end
  end

  // Output slot: flush beats reload, reload beats consume.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_adel  <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (fill) begin
      if_valid <= 1'b1;
      if_pc    <= req_pc;
      if_inst  <= inst_sram_rdata;
      if_adel  <= 1'b0;
    end else if (ill_load) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_inst  <= NOP_INST;
      if_adel  <= 1'b1;
    end else if (id_allowin) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc = 32'hbfc0_0000;
  logic        illegal_pc_if;
  logic        flush = 1'b0;
  logic [31:0] flush_tgt = '0;
  logic        pc_en;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin = 1'b1;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  logic        aok = 1'b1;
  int          data_delay = 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;
  exp_t sb[$];

  assign illegal_pc_if     = (pc[1:0] != 2'b00);
  assign inst_sram_addr_ok = aok;

  inst_fetch_unit #(.NOP_INST(32'h0000_0000)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .pc                (pc),
    .illegal_pc_if     (illegal_pc_if),
    .flush             (flush),
    .pc_en             (pc_en),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .id_allowin        (id_allowin),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .if_adel           (if_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic a);
    exp_t e;
    e.pc = p; e.inst = i; e.adel = a;
    sb.push_back(e);
  endtask

  // PC register: advances by 4 on pc_en, loads the redirect target on flush.
  initial begin
    logic [31:0] nxt;
    forever begin
      @(negedge clk);
      nxt = pc;
      if (resetn && pc_en) nxt = flush ? flush_tgt : pc + 32'd4;
      @(posedge clk); #1;
      pc = nxt;
    end
  end

  // SRAM: returns addr + 0x1000_0000 data_delay cycles after acceptance.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    forever begin
      @(negedge clk);
      if (inst_sram_req && inst_sram_addr_ok) begin
        pend = 1'b1; pend_addr = inst_sram_addr; pend_cnt = data_delay;
      end
      @(posedge clk); #1;
      inst_sram_data_ok = 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = pend_addr + 32'h1000_0000;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  // Monitor: every slot handed to decode must match the next expected entry.
  always @(negedge clk) begin
    if (resetn === 1'b1 && if_valid && id_allowin) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected: got pc %h inst %h adel %b expected no entry", if_pc, if_inst, if_adel);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst || if_adel !== e.adel) begin
          errors++;
          $display("FAIL slot_entry: got pc %h inst %h adel %b expected pc %h inst %h adel %b",
                   if_pc, if_inst, if_adel, e.pc, e.inst, e.adel);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_adel", if_adel, 0);
    chk("rst_req", inst_sram_req, 0);
    chk("rst_pc_en", pc_en, 0);

    // C1: first request right after reset release
    cyc(); resetn = 1'b1; push(32'hbfc0_0000, 32'hcfc0_0000, 1'b0);
    smp();
    chk("c1_req", inst_sram_req, 1);
    chk("c1_addr", inst_sram_addr, 32'hbfc0_0000);
    chk("c1_pc_en", pc_en, 1);
    // C2: waiting for data
    cyc(); smp();
    chk("c2_req", inst_sram_req, 0);
    chk("c2_pc_en", pc_en, 0);
    chk("c2_if_valid", if_valid, 0);
    // C3: slot valid, next request out
    cyc(); push(32'hbfc0_0004, 32'hcfc0_0004, 1'b0); smp();
    chk("c3_if_valid", if_valid, 1);
    chk("c3_req", inst_sram_req, 1);
    chk("c3_addr", inst_sram_addr, 32'hbfc0_0004);
    chk("c3_pc_en", pc_en, 1);
    // C4
    cyc(); smp();
    chk("c4_if_valid", if_valid, 0);
    // C5..C9: decode stall
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) id_allowin = 1'b0;
      smp();
      chk("stall_if_valid", if_valid, 1);
      chk("stall_if_pc", if_pc, 32'hbfc0_0004);
      chk("stall_if_inst", if_inst, 32'hcfc0_0004);
      chk("stall_req", inst_sram_req, 0);
      chk("stall_pc_en", pc_en, 0);
    end
    // C10: decode resumes, fetch resumes the same cycle
    cyc(); id_allowin = 1'b1; push(32'hbfc0_0008, 32'hcfc0_0008, 1'b0); smp();
    chk("resume_req", inst_sram_req, 1);
    chk("resume_addr", inst_sram_addr, 32'hbfc0_0008);
    chk("resume_pc_en", pc_en, 1);
    // C11
    cyc(); smp();
    // C12..C14: addr_ok low
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) aok = 1'b0;
      smp();
      chk("aok_req", inst_sram_req, 1);
      chk("aok_addr", inst_sram_addr, 32'hbfc0_000c);
      chk("aok_pc_en", pc_en, 0);
    end
    // C15: accepted
    cyc(); aok = 1'b1; push(32'hbfc0_000c, 32'hcfc0_000c, 1'b0); smp();
    chk("aok_acc_req", inst_sram_req, 1);
    chk("aok_acc_pc_en", pc_en, 1);
    // C16, C17: request for bfc00010 accepted in C17 with slow data
    cyc(); smp();
    cyc(); data_delay = 2; smp();
    chk("c17_addr", inst_sram_addr, 32'hbfc0_0010);
    // C18: flush one cycle after accept
    cyc(); flush = 1'b1; flush_tgt = 32'h8000_0000; smp();
    chk("fl_req", inst_sram_req, 0);
    chk("fl_pc_en", pc_en, 1);
    // C19: stale data arrives in DROP
    cyc(); flush = 1'b0; data_delay = 1; smp();
    chk("drop_data_ok", inst_sram_data_ok, 1);
    chk("drop_req", inst_sram_req, 0);
    chk("drop_pc_en", pc_en, 0);
    chk("drop_if_valid", if_valid, 0);
    // C20: redirected fetch
    cyc(); push(32'h8000_0000, 32'h9000_0000, 1'b0); smp();
    chk("redir_if_valid", if_valid, 0);
    chk("redir_req", inst_sram_req, 1);
    chk("redir_addr", inst_sram_addr, 32'h8000_0000);
    // C21, C22
    cyc(); smp();
    chk("c21_if_valid", if_valid, 0);
    cyc(); smp();
    chk("c22_if_valid", if_valid, 1);
    // C23: flush coincident with data_ok
    cyc(); flush = 1'b1; flush_tgt = 32'h8000_0100; smp();
    chk("flco_data_ok", inst_sram_data_ok, 1);
    chk("flco_req", inst_sram_req, 0);
    chk("flco_pc_en", pc_en, 1);
    // C24: no slot load, back in IDLE
    cyc(); flush = 1'b0; push(32'h8000_0100, 32'h9000_0100, 1'b0); smp();
    chk("flco_if_valid", if_valid, 0);
    chk("flco_next_req", inst_sram_req, 1);
    chk("flco_next_addr", inst_sram_addr, 32'h8000_0100);
    // C25, C26
    cyc(); smp();
    cyc(); aok = 1'b0; smp();
    chk("c26_req", inst_sram_req, 1);
    chk("c26_pc_en", pc_en, 0);
    // C27: redirect to a misaligned address
    cyc(); flush = 1'b1; flush_tgt = 32'hbfc0_0002; smp();
    chk("c27_req", inst_sram_req, 0);
    chk("c27_pc_en", pc_en, 1);
    // C28: address-error load
    cyc(); flush = 1'b0; push(32'hbfc0_0002, 32'h0000_0000, 1'b1); smp();
    chk("adel_addr", inst_sram_addr, 32'hbfc0_0002);
    chk("adel_req", inst_sram_req, 0);
    chk("adel_pc_en", pc_en, 1);
    chk("adel_pre_valid", if_valid, 0);
    // C29: error entry visible
    cyc(); flush = 1'b1; flush_tgt = 32'h8000_0200; smp();
    chk("adel_if_valid", if_valid, 1);
    chk("adel_if_adel", if_adel, 1);
    chk("adel_if_inst", if_inst, 32'h0000_0000);
    chk("adel_if_pc", if_pc, 32'hbfc0_0002);
    chk("adel_fl_pc_en", pc_en, 1);
    // C30: clean fetch after recovery
    cyc(); flush = 1'b0; aok = 1'b1; push(32'h8000_0200, 32'h9000_0200, 1'b0); smp();
    chk("rec_req", inst_sram_req, 1);
    chk("rec_addr", inst_sram_addr, 32'h8000_0200);
    chk("rec_pc_en", pc_en, 1);
    cyc(); smp();
    cyc(); aok = 1'b0; smp();
    chk("rec_if_valid", if_valid, 1);
    cyc(); cyc(); smp();
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage that sits directly downstream of the PC register and upstream of decode. Each cycle it may issue the current PC to the instruction SRAM over a req/addr_ok/data_ok handshake. It keeps one request in flight, holds the returned instruction in a one-entry output slot until decode accepts it, and drops stale responses after a branch or exception redirect. It drives `pc_en` back to the PC register so the PC only advances once the SRAM has accepted the address or the stage has been flushed.

## Interface
Parameters:
- `NOP_INST`, 32'h0000_0000, instruction word placed in the slot for an address-error fetch.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `pc`  in  32  current fetch address from the PC register.
- `illegal_pc_if`  in  1  `pc[1:0] != 0`, from the PC register.
- `flush`  in  1  branch or exception redirect this cycle; the PC register loads the new target at the next edge.
- `pc_en`  out  1  PC register update enable.
- `inst_sram_req`  out  1  fetch request.
- `inst_sram_addr`  out  32  fetch address; always equal to `pc`.
- `inst_sram_addr_ok`  in  1  address accepted this cycle, valid with `req`.
- `inst_sram_data_ok`  in  1  read data valid this cycle; responses return in order.
- `inst_sram_rdata`  in  32  instruction word.
- `id_allowin`  in  1  decode accepts the slot contents this cycle.
- `if_valid`  out  1  output slot holds an instruction.
- `if_pc`  out  32  PC of the slot instruction.
- `if_inst`  out  32  slot instruction.
- `if_adel`  out  1  fetch address error flag for the slot entry.

## Operation
- FSM has three states.
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its data will fill the slot.
  - DROP: one request outstanding whose data must be discarded.
- `slot_free` = `!if_valid | id_allowin`.
- `inst_sram_req` = IDLE & `slot_free` & `!flush` & `!illegal_pc_if` & `resetn`.
- `accept` = `req & addr_ok`. On accept, latch `pc` into `req_pc` and go to WAIT.
- Address-error load, `ill_load` = IDLE & `slot_free` & `!flush` & `illegal_pc_if`:
  - no SRAM request is issued;
  - the slot loads {`pc`, `NOP_INST`, adel=1} and `if_valid` is set;
  - state stays IDLE.
- `pc_en` = (`accept` | `ill_load` | `flush`) & `resetn`.
- WAIT with `data_ok` and no `flush`: the slot loads {`req_pc`, `rdata`, adel=0}, `if_valid`=1, then go to IDLE.
- WAIT with `flush`: go to DROP. If `data_ok` arrives in the same cycle, discard it and go to IDLE.
- DROP with `data_ok`: discard and go to IDLE. A `flush` while in DROP keeps DROP.
- Slot consume: `if_valid` & `id_allowin` with no reload in the same cycle clears `if_valid`. A reload in the same cycle takes precedence.
- `flush` clears `if_valid` in all states and has priority over consume and reload.
- The slot can never overflow: a request issues only when the slot is free. Hold `if_pc`, `if_inst` and `if_adel` stable while `if_valid` & `!id_allowin`.

## Timing
- Asynchronous reset values:
  - state = IDLE;
  - `if_valid` = 0, `if_pc` = 0, `if_inst` = 0, `if_adel` = 0, `req_pc` = 0;
  - `req` and `pc_en` forced to 0 while `resetn` is low.
- First request is asserted in the first cycle after `resetn` rises.
- Zero-wait SRAM (`addr_ok`=1, `data_ok` the following cycle):
  - request in cycle n, data in n+1, `if_valid` from n+2;
  - sustained rate is 1 instruction per 2 cycles.
- `flush` takes effect in the same cycle: `req` is suppressed and `pc_en`=1. The redirected fetch issues at the earliest one cycle later, or on leaving DROP.
- Reset asserted mid-request drops the request without waiting for `data_ok`. The SRAM interface is reset by the same `resetn`.

## Structure
- Shared package:
  - FSM state encoding {IDLE, WAIT, DROP};
  - `NOP_INST` default;
  - the 32-bit address/instruction width constant.
- No sub-modules; the FSM and slot register are a single module.

## Test plan
- Zero-wait SRAM, `id_allowin`=1, reset release with pc=0xbfc00000:
  - `req` is seen in cycle 1;
  - `if_valid` with `if_pc`=0xbfc00000 and `if_inst`=`rdata` in cycle 3;
  - `pc_en` pulses once per accepted request.
- Decode stall: `id_allowin`=0 for 5 cycles after a fill:
  - slot holds steady;
  - `req` stays 0 and `pc_en` stays 0;
  - the fetch resumes the cycle `id_allowin` returns.
- `addr_ok` held low 3 cycles:
  - `req` and `addr` stay stable;
  - `pc_en`=0 until the accept cycle.
- `flush` one cycle after accept, `data_ok` two cycles later:
  - response discarded and `if_valid` stays 0;
  - the next request carries the redirected pc.
- `flush` coincident with `data_ok` in WAIT: no slot load, next state IDLE.
- pc=0xbfc00002:
  - no `req`;
  - `if_valid`=1, `if_adel`=1, `if_inst`=0, `if_pc`=0xbfc00002;
  - `pc_en`=1.
